// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back FIFO draining one register write per cycle onto the GRF port.
// Define GRF_WB_BYPASS_EN to build the newest-pending-value bypass lookup.
module grf_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    input  logic [31:0]   in_pc,
    input  logic          drain_en,
    output logic          grf_we,
    output logic [4:0]    grf_a3,
    output logic [31:0]   grf_wd,
    output logic [31:0]   grf_pc,
    output logic [AW:0]   count,
    input  logic [4:0]    rd_addr1,
    input  logic [4:0]    rd_addr2,
    output logic          byp_hit1,
    output logic [31:0]   byp_data1,
    output logic          byp_hit2,
    output logic [31:0]   byp_data2
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_nonempty;
    logic w_push;
    logic w_pop;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count < LP_DEPTH);
    // Writes to $0 complete the handshake but never enter the queue.
    assign w_push     = in_valid & in_ready & (in_addr != 5'd0);
    assign w_pop      = w_nonempty & drain_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= in_addr;
            r_data[r_wr_ptr] <= in_data;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    assign count  = r_count;
    assign grf_we = w_pop;
    assign grf_a3 = w_nonempty ? r_addr[r_rd_ptr] : 5'd0;
    assign grf_wd = w_nonempty ? r_data[r_rd_ptr] : 32'd0;
    assign grf_pc = w_nonempty ? r_pc[r_rd_ptr]   : 32'd0;

`ifdef GRF_WB_BYPASS_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [AW-1:0] w_idx;
        byp_hit1  = 1'b0;
        byp_data1 = 32'd0;
        byp_hit2  = 1'b0;
        byp_data2 = 32'd0;
        w_idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if ((rd_addr1 != 5'd0) && (r_addr[w_idx] == rd_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = r_data[w_idx];
                end
                if ((rd_addr2 != 5'd0) && (r_addr[w_idx] == rd_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = r_data[w_idx];
                end
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{rd_addr1, rd_addr2};
    assign byp_hit1  = 1'b0;
    assign byp_data1 = 32'd0;
    assign byp_hit2  = 1'b0;
    assign byp_data2 = 32'd0;
`endif

endmodule
